// File: rtl/el2_pkg.sv
// Shared types for the LSU trigger sequencer: trigger configuration record,
// sequencer states, action encodings and a small priority helper.
package el2_pkg;

  localparam int EL2_NUM_TRIG = 4;
  localparam int EL2_CNT_W    = 8;

  localparam logic TRIG_ACT_BRK = 1'b0;  // breakpoint exception
  localparam logic TRIG_ACT_DBG = 1'b1;  // debug halt

  typedef struct packed {
    logic                 en;
    logic                 chain;
    logic                 action;
    logic [EL2_CNT_W-1:0] thresh;
  } el2_trig_cfg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } el2_trig_st_e;

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/el2_lsu_trig_counter.sv
// Per-trigger saturating match counter with threshold compare.
// A match fires once the running count (including this match) reaches the
// threshold; the count then restarts from zero. Threshold 0 or 1 fires on
// every match. A configuration write to the trigger clears the count.
module el2_lsu_trig_counter
  #(parameter int CNT_W = 8)
  (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] thresh,
    output logic             fire
  );

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_plus1;

  assign cnt_plus1 = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign fire      = inc & (cnt_plus1 >= {1'b0, thresh});

  // Count eligible matches, restart after a fire, hold at all-ones.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt <= '0;
    end else if (clr || fire) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/el2_lsu_trigger_ctrl.sv
// M-stage LSU data-trigger sequencer.
// Qualifies raw trigger matches (enable, 0-1 / 2-3 chaining, optional
// match-count threshold), keeps sticky hit bits and raises one prioritized
// request toward the exception/debug unit.
// Optional feature macro: RV_TRIG_COUNT_EN (per-trigger match counters).
//
// Handshake: trig_req_valid rises one cycle after the qualifying match and
// stays high with trig_req_idx/trig_req_action stable until a cycle where
// trig_req_valid & trig_req_ready are both high; that cycle is the transfer.
module el2_lsu_trigger_ctrl
  import el2_pkg::*;
  #(parameter int NUM_TRIG = EL2_NUM_TRIG,
    parameter int CNT_W    = EL2_CNT_W)
  (
    input  logic                clk,
    input  logic                rst_l,
    input  logic [NUM_TRIG-1:0] lsu_trigger_match_m,
    input  logic                lsu_valid_m,
    input  logic                flush_m,
    input  logic                cfg_wr_en,
    input  logic [1:0]          cfg_wr_idx,
    input  el2_trig_cfg_t       cfg_wr_data,
    input  logic [NUM_TRIG-1:0] hit_clr,
    input  logic                trig_req_ready,
    output logic                trig_req_valid,
    output logic [1:0]          trig_req_idx,
    output logic                trig_req_action,
    output logic [NUM_TRIG-1:0] trig_hit,
    output logic                trig_busy,
    output logic [1:0]          dbg_state
  );

  // Configuration storage; chain is only meaningful on the even index of a pair.
  logic [NUM_TRIG-1:0]   cfg_en;
  logic [NUM_TRIG-1:0]   cfg_act;
  logic [NUM_TRIG/2-1:0] cfg_chain_pair;

  logic [NUM_TRIG-1:0] q;
  logic [NUM_TRIG-1:0] elig;
  logic [NUM_TRIG-1:0] fire;

  el2_trig_st_e        state, state_nxt;
  logic [1:0]          idx_nxt;
  logic                act_nxt;
  logic [NUM_TRIG-1:0] hit_nxt;

  // Configuration writes take effect for qualification from the next cycle.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cfg_en         <= '0;
      cfg_act        <= '0;
      cfg_chain_pair <= '0;
    end else if (cfg_wr_en) begin
      cfg_en[cfg_wr_idx]  <= cfg_wr_data.en;
      cfg_act[cfg_wr_idx] <= cfg_wr_data.action;
      if (!cfg_wr_idx[0]) cfg_chain_pair[cfg_wr_idx[1]] <= cfg_wr_data.chain;
    end
  end

  // Raw qualification: live, unflushed, enabled, matching.
  assign q = {NUM_TRIG{lsu_valid_m & ~flush_m}} & cfg_en & lsu_trigger_match_m;

  // Chained pairs report only on the odd index and require both halves.
  for (genvar p = 0; p < NUM_TRIG/2; p++) begin : g_pair
    assign elig[2*p]   = q[2*p] & ~cfg_chain_pair[p];
    assign elig[2*p+1] = cfg_chain_pair[p] ? (q[2*p] & q[2*p+1]) : q[2*p+1];
  end

`ifdef RV_TRIG_COUNT_EN
  logic [CNT_W-1:0] cfg_thresh [NUM_TRIG];

  // Threshold per trigger, written alongside the rest of the configuration.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < NUM_TRIG; i++) cfg_thresh[i] <= '0;
    end else if (cfg_wr_en) begin
      cfg_thresh[cfg_wr_idx] <= cfg_wr_data.thresh;
    end
  end

  for (genvar i = 0; i < NUM_TRIG; i++) begin : g_cnt
    el2_lsu_trig_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst_l  (rst_l),
      .clr    (cfg_wr_en && (cfg_wr_idx == 2'(i))),
      .inc    (elig[i]),
      .thresh (cfg_thresh[i]),
      .fire   (fire[i])
    );
  end
`else
  logic [CNT_W-1:0] unused_thresh;
  assign unused_thresh = cfg_wr_data.thresh;
  assign fire          = elig;
`endif

  // Next-state, next hit vector and request capture.
  always_comb begin
    state_nxt = state;
    idx_nxt   = trig_req_idx;
    act_nxt   = trig_req_action;
    hit_nxt   = (trig_hit & ~hit_clr) | fire;
    case (state)
      IDLE: begin
        if (|fire) begin
          idx_nxt   = lowest_idx(fire);
          act_nxt   = cfg_act[lowest_idx(fire)];
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (trig_req_ready) state_nxt = HOLD;
      end
      HOLD: begin
        if (hit_nxt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer registers; reset drops a pending request immediately.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state           <= IDLE;
      trig_req_idx    <= 2'd0;
      trig_req_action <= TRIG_ACT_BRK;
      trig_hit        <= '0;
    end else begin
      state           <= state_nxt;
      trig_req_idx    <= idx_nxt;
      trig_req_action <= act_nxt;
      trig_hit        <= hit_nxt;
    end
  end

  assign trig_req_valid = (state == REQ);
  assign trig_busy      = (state != IDLE);
  assign dbg_state      = state;

endmodule

// File: tb/tb_el2_lsu_trigger_ctrl.sv
// Directed bench for el2_lsu_trigger_ctrl with hand-computed expectations.
module tb_el2_lsu_trigger_ctrl;
  import el2_pkg::*;

  logic          clk;
  logic          rst_l;
  logic [3:0]    lsu_trigger_match_m;
  logic          lsu_valid_m;
  logic          flush_m;
  logic          cfg_wr_en;
  logic [1:0]    cfg_wr_idx;
  el2_trig_cfg_t cfg_wr_data;
  logic [3:0]    hit_clr;
  logic          trig_req_ready;
  logic          trig_req_valid;
  logic [1:0]    trig_req_idx;
  logic          trig_req_action;
  logic [3:0]    trig_hit;
  logic          trig_busy;
  logic [1:0]    dbg_state;

  int n_chk;
  int n_pass;

  el2_lsu_trigger_ctrl dut (
    .clk                 (clk),
    .rst_l               (rst_l),
    .lsu_trigger_match_m (lsu_trigger_match_m),
    .lsu_valid_m         (lsu_valid_m),
    .flush_m             (flush_m),
    .cfg_wr_en           (cfg_wr_en),
    .cfg_wr_idx          (cfg_wr_idx),
    .cfg_wr_data         (cfg_wr_data),
    .hit_clr             (hit_clr),
    .trig_req_ready      (trig_req_ready),
    .trig_req_valid      (trig_req_valid),
    .trig_req_idx        (trig_req_idx),
    .trig_req_action     (trig_req_action),
    .trig_hit            (trig_hit),
    .trig_busy           (trig_busy),
    .dbg_state           (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; sample point is just after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic en, input logic chain,
                           input logic act, input logic [7:0] th);
    cfg_wr_en   = 1'b1;
    cfg_wr_idx  = idx;
    cfg_wr_data = {en, chain, act, th};
    cycle();
    cfg_wr_en   = 1'b0;
  endtask

  task automatic drive_match(input logic [3:0] m);
    lsu_valid_m         = 1'b1;
    lsu_trigger_match_m = m;
    cycle();
    lsu_valid_m         = 1'b0;
    lsu_trigger_match_m = 4'b0;
  endtask

  task automatic accept();
    trig_req_ready = 1'b1;
    cycle();
    trig_req_ready = 1'b0;
  endtask

  task automatic clear_hits(input logic [3:0] m);
    hit_clr = m;
    cycle();
    hit_clr = 4'b0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_l = 1'b0;
    lsu_trigger_match_m = 4'b0;
    lsu_valid_m = 1'b0;
    flush_m = 1'b0;
    cfg_wr_en = 1'b0;
    cfg_wr_idx = 2'd0;
    cfg_wr_data = '0;
    hit_clr = 4'b0;
    trig_req_ready = 1'b0;

    // Reset state
    #2;
    check("rst_valid", 32'(trig_req_valid), 32'd0);
    check("rst_idx", 32'(trig_req_idx), 32'd0);
    check("rst_action", 32'(trig_req_action), 32'd0);
    check("rst_hit", 32'(trig_hit), 32'd0);
    check("rst_busy", 32'(trig_busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    cycle();
    rst_l = 1'b1;
    cycle();

    // Single trigger 2, debug-halt action, full handshake and clear
    cfg_write(2'd2, 1'b1, 1'b0, 1'b1, 8'd0);
    drive_match(4'b0100);
    check("t1_valid", 32'(trig_req_valid), 32'd1);
    check("t1_idx", 32'(trig_req_idx), 32'd2);
    check("t1_action", 32'(trig_req_action), 32'd1);
    check("t1_hit", 32'(trig_hit), 32'h4);
    check("t1_busy", 32'(trig_busy), 32'd1);
    check("t1_state_req", 32'(dbg_state), 32'd1);
    accept();
    check("t1_hold_valid", 32'(trig_req_valid), 32'd0);
    check("t1_hold_busy", 32'(trig_busy), 32'd1);
    check("t1_state_hold", 32'(dbg_state), 32'd2);
    clear_hits(4'b0100);
    check("t1_clr_hit", 32'(trig_hit), 32'd0);
    check("t1_clr_busy", 32'(trig_busy), 32'd0);

    // Triggers 0 and 3 together: lowest index wins, request held stable
    cfg_write(2'd2, 1'b0, 1'b0, 1'b0, 8'd0);
    cfg_write(2'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    cfg_write(2'd3, 1'b1, 1'b0, 1'b1, 8'd0);
    drive_match(4'b1001);
    check("t2_valid", 32'(trig_req_valid), 32'd1);
    check("t2_idx", 32'(trig_req_idx), 32'd0);
    check("t2_action", 32'(trig_req_action), 32'd0);
    check("t2_hit", 32'(trig_hit), 32'h9);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check($sformatf("t2_stall%0d_valid", i), 32'(trig_req_valid), 32'd1);
      check($sformatf("t2_stall%0d_idx", i), 32'(trig_req_idx), 32'd0);
      check($sformatf("t2_stall%0d_action", i), 32'(trig_req_action), 32'd0);
    end
    accept();
    check("t2_hold_valid", 32'(trig_req_valid), 32'd0);
    // Fire in HOLD together with a clear of the same bit: set wins, no request
    hit_clr             = 4'b0001;
    lsu_valid_m         = 1'b1;
    lsu_trigger_match_m = 4'b0001;
    cycle();
    hit_clr             = 4'b0;
    lsu_valid_m         = 1'b0;
    lsu_trigger_match_m = 4'b0;
    check("t2_setwins_hit", 32'(trig_hit), 32'h9);
    check("t2_hold_fire_valid", 32'(trig_req_valid), 32'd0);
    check("t2_hold_fire_state", 32'(dbg_state), 32'd2);
    cycle();
    check("t2_hold_stays_valid", 32'(trig_req_valid), 32'd0);
    clear_hits(4'b0001);
    check("t2_partial_clr_hit", 32'(trig_hit), 32'h8);
    check("t2_partial_clr_busy", 32'(trig_busy), 32'd1);
    clear_hits(4'b1000);
    check("t2_clr_busy", 32'(trig_busy), 32'd0);

    // Flushed op: no fire, no hit
    flush_m = 1'b1;
    drive_match(4'b0001);
    flush_m = 1'b0;
    check("t3_flush_valid", 32'(trig_req_valid), 32'd0);
    check("t3_flush_hit", 32'(trig_hit), 32'd0);
    check("t3_flush_busy", 32'(trig_busy), 32'd0);

    // Chained pair 0-1
    cfg_write(2'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    cfg_write(2'd0, 1'b1, 1'b1, 1'b0, 8'd0);
    cfg_write(2'd1, 1'b1, 1'b0, 1'b1, 8'd0);
    drive_match(4'b0001);
    check("t4_half0_valid", 32'(trig_req_valid), 32'd0);
    check("t4_half0_hit", 32'(trig_hit), 32'd0);
    drive_match(4'b0010);
    check("t4_half1_valid", 32'(trig_req_valid), 32'd0);
    check("t4_half1_hit", 32'(trig_hit), 32'd0);
    drive_match(4'b0011);
    check("t4_both_valid", 32'(trig_req_valid), 32'd1);
    check("t4_both_idx", 32'(trig_req_idx), 32'd1);
    check("t4_both_action", 32'(trig_req_action), 32'd1);
    check("t4_both_hit", 32'(trig_hit), 32'h2);
    // Rewriting the pending trigger's cfg leaves the request untouched
    cfg_write(2'd1, 1'b1, 1'b0, 1'b0, 8'd0);
    check("t4_cfgwr_valid", 32'(trig_req_valid), 32'd1);
    check("t4_cfgwr_idx", 32'(trig_req_idx), 32'd1);
    check("t4_cfgwr_action", 32'(trig_req_action), 32'd1);
    accept();
    clear_hits(4'b0010);
    check("t4_clr_busy", 32'(trig_busy), 32'd0);

    // Match-count threshold on trigger 1
    cfg_write(2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    cfg_write(2'd1, 1'b1, 1'b0, 1'b0, 8'd3);
`ifdef RV_TRIG_COUNT_EN
    drive_match(4'b0010);
    check("t5_cnt1_valid", 32'(trig_req_valid), 32'd0);
    drive_match(4'b0010);
    check("t5_cnt2_valid", 32'(trig_req_valid), 32'd0);
    check("t5_cnt2_hit", 32'(trig_hit), 32'd0);
    drive_match(4'b0010);
    check("t5_cnt3_valid", 32'(trig_req_valid), 32'd1);
    check("t5_cnt3_idx", 32'(trig_req_idx), 32'd1);
    check("t5_cnt3_hit", 32'(trig_hit), 32'h2);
    accept();
    clear_hits(4'b0010);
    drive_match(4'b0010);
    check("t5_cnt4_valid", 32'(trig_req_valid), 32'd0);
    check("t5_cnt4_hit", 32'(trig_hit), 32'd0);
`else
    drive_match(4'b0010);
    check("t5_nothresh_valid", 32'(trig_req_valid), 32'd1);
    check("t5_nothresh_idx", 32'(trig_req_idx), 32'd1);
    check("t5_nothresh_hit", 32'(trig_hit), 32'h2);
    accept();
    clear_hits(4'b0010);
    check("t5_clr_busy", 32'(trig_busy), 32'd0);
`endif

    // Asynchronous reset in the middle of a request
    cfg_write(2'd1, 1'b0, 1'b0, 1'b0, 8'd0);
    cfg_write(2'd2, 1'b1, 1'b0, 1'b1, 8'd0);
    drive_match(4'b0100);
    check("t6_pre_valid", 32'(trig_req_valid), 32'd1);
    #2;
    rst_l = 1'b0;
    #1;
    check("t6_async_valid", 32'(trig_req_valid), 32'd0);
    check("t6_async_hit", 32'(trig_hit), 32'd0);
    check("t6_async_busy", 32'(trig_busy), 32'd0);
    check("t6_async_idx", 32'(trig_req_idx), 32'd0);
    check("t6_async_action", 32'(trig_req_action), 32'd0);
    #2;
    rst_l = 1'b1;
    cycle();
    // Configuration was cleared, so the same match no longer fires
    drive_match(4'b0100);
    check("t6_cfg_cleared_valid", 32'(trig_req_valid), 32'd0);
    check("t6_cfg_cleared_hit", 32'(trig_hit), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
